ascii_bit_packer: RTL and testbench

Converts a stream of UART receive bytes carrying ASCII '0'/'1' characters into DATA_W-bit binary words for the Hamming encoder/decoder datapath. It sits between the UART receiver (rx byte + done tick) and the codec core. Assembled words are buffered in an internal FIFO with a valid/ready output handshake. Non-binary characters, terminators, partial words and overflow are handled explicitly.

---
 rtl/ascii_bit_packer_pkg.sv | 35 +++
 rtl/ascii_bit_packer_fifo.sv | 59 +++++
 rtl/ascii_bit_packer.sv | 118 +++++++++++
 tb/tb_ascii_bit_packer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_bit_packer_pkg.sv
// Shared constants, state and character-class types for the ASCII bit packer.
package ascii_bit_packer_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_ONE  = 8'h31;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_SP   = 8'h20;

   typedef enum logic {
      COLLECT = 1'b0,
      PUSH    = 1'b1
   } pack_state_e;

   typedef enum logic [2:0] {
      BIT0    = 3'd0,
      BIT1    = 3'd1,
      TERM    = 3'd2,
      SKIP    = 3'd3,
      ILLEGAL = 3'd4
   } char_class_e;

   function automatic char_class_e classify(input logic [7:0] c);
      char_class_e cls;
      case (c)
         ASCII_ZERO:         cls = BIT0;
         ASCII_ONE:          cls = BIT1;
         ASCII_CR, ASCII_LF: cls = TERM;
         ASCII_SP:           cls = SKIP;
         default:            cls = ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/ascii_bit_packer_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only alongside a pop.
module sync_fifo_fwft #(
   parameter int unsigned B = 8,
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [B-1:0] data_i,
   input  logic         pop_i,
   output logic [B-1:0] data_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int unsigned DEPTH = 1 << W;

   logic [B-1:0] mem_q [DEPTH];
   logic [W-1:0] wr_ptr_q, rd_ptr_q;
   logic [W-1:0] wr_ptr_inc, rd_ptr_inc;
   logic         empty_q, full_q;
   logic         do_push, do_pop;

   always_comb begin
      do_pop     = pop_i & ~empty_q;
      do_push    = push_i & (~full_q | do_pop);
      wr_ptr_inc = wr_ptr_q + W'(1);
      rd_ptr_inc = rd_ptr_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_inc;
         if (do_pop)  rd_ptr_q <= rd_ptr_inc;
         if (do_push && !do_pop) begin
            empty_q <= 1'b0;
            full_q  <= (wr_ptr_inc == rd_ptr_q);
         end else if (do_pop && !do_push) begin
            full_q  <= 1'b0;
            empty_q <= (rd_ptr_inc == wr_ptr_q);
         end
      end
   end

   // Head word is forced to zero when empty so the output is clean out of reset.
   assign data_o  = empty_q ? '0 : mem_q[rd_ptr_q];
   assign empty_o = empty_q;
   assign full_o  = full_q;

endmodule

// File: rtl/ascii_bit_packer.sv
// Packs ASCII '0'/'1' UART characters into DATA_W-bit words buffered in a FWFT FIFO.
// Define ASCII_PACK_PAD_EN to zero-pad and push partial words on a terminator.
module ascii_bit_packer
   import ascii_bit_packer_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_valid,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         full,
   output logic [$clog2(DATA_W+1)-1:0]  bit_cnt,
   output logic                         err_char,
   output logic                         err_short,
   output logic                         overflow,
   input  logic                         clr_ovf
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);
   localparam int unsigned IDX_W = $clog2(DATA_W);

   pack_state_e       state_q;
   logic [DATA_W-1:0] shift_q, shift_base, shift_d;
   logic [CNT_W-1:0]  bit_cnt_q, cnt_base, cnt_d;
   logic [IDX_W-1:0]  bit_idx;
   char_class_e       cls;
   logic              err_char_q, err_short_q, overflow_q;
   logic              fifo_empty, fifo_full;
   logic              push_c, pop_c, ovf_set_c;

   // PUSH clears the accumulator; a bit arriving in that cycle merges onto the cleared value.
   always_comb begin
      cls        = classify(rx_data);
      cnt_base   = (state_q == PUSH) ? '0 : bit_cnt_q;
      shift_base = (state_q == PUSH) ? '0 : shift_q;
      bit_idx    = (MSB_FIRST != 0) ? (IDX_W'(DATA_W - 1) - IDX_W'(cnt_base))
                                    : IDX_W'(cnt_base);
      shift_d          = shift_base;
      shift_d[bit_idx] = (cls == BIT1);
      cnt_d            = cnt_base + CNT_W'(1);
   end

   always_comb begin
      push_c    = (state_q == PUSH);
      pop_c     = ~fifo_empty & out_ready;
      ovf_set_c = push_c & fifo_full & ~pop_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= COLLECT;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         err_char_q  <= 1'b0;
         err_short_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         err_char_q  <= 1'b0;
         err_short_q <= 1'b0;
         state_q     <= COLLECT;
         shift_q     <= shift_base;
         bit_cnt_q   <= cnt_base;
         if (rx_valid) begin
            case (cls)
               BIT0, BIT1: begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= cnt_d;
                  if (cnt_d == CNT_W'(DATA_W)) state_q <= PUSH;
               end
               TERM: begin
                  if (cnt_base != '0) begin
                     err_short_q <= 1'b1;
`ifdef ASCII_PACK_PAD_EN
                     state_q     <= PUSH;
`else
                     shift_q     <= '0;
                     bit_cnt_q   <= '0;
`endif
                  end
               end
               ILLEGAL: err_char_q <= 1'b1;
               default: ;
            endcase
         end
         // A new overflow outranks a clear in the same cycle.
         if (ovf_set_c)    overflow_q <= 1'b1;
         else if (clr_ovf) overflow_q <= 1'b0;
      end
   end

   sync_fifo_fwft #(
      .B (DATA_W),
      .W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_c),
      .data_i  (shift_q),
      .pop_i   (pop_c),
      .data_o  (out_data),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign out_valid = ~fifo_empty;
   assign full      = fifo_full;
   assign bit_cnt   = bit_cnt_q;
   assign err_char  = err_char_q;
   assign err_short = err_short_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_ascii_bit_packer.sv
// Scoreboard bench: MSB-first packer with a 4-deep FIFO plus an LSB-first twin on the same stream.
module tb_ascii_bit_packer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       lsb_ready = 1'b1;
   logic       lsb_clr = 1'b0;

   logic [7:0] out_data, lsb_data;
   logic       out_valid, lsb_valid, full, lsb_full;
   logic [3:0] bit_cnt, lsb_cnt;
   logic       err_char, err_short, overflow;
   logic       lsb_errc, lsb_errs, lsb_ovf;

   int n_checks = 0;
   int n_pass   = 0;
   int n_errc   = 0;
   int n_errs   = 0;
   logic [7:0] exp_main[$];
   logic [7:0] exp_lsb[$];

   always #5 clk = ~clk;

   ascii_bit_packer #(.DATA_W(8), .ADDR_W(2), .MSB_FIRST(1)) u_dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .full(full), .bit_cnt(bit_cnt), .err_char(err_char), .err_short(err_short),
      .overflow(overflow), .clr_ovf(clr_ovf)
   );

   ascii_bit_packer #(.DATA_W(8), .ADDR_W(2), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .out_data(lsb_data), .out_valid(lsb_valid), .out_ready(lsb_ready),
      .full(lsb_full), .bit_cnt(lsb_cnt), .err_char(lsb_errc), .err_short(lsb_errs),
      .overflow(lsb_ovf), .clr_ovf(lsb_clr)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Characters go out back-to-back; returns one cycle after the last one is sampled.
   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         rx_data  = s[i];
         rx_valid = 1'b1;
         step();
      end
      rx_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] c);
      rx_data  = c;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic expect_word(input logic [7:0] m, input logic [7:0] l, input bit keep_main);
      if (keep_main) exp_main.push_back(m);
      exp_lsb.push_back(l);
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while ((exp_main.size() != 0 || exp_lsb.size() != 0) && i < 60) begin
         step();
         i++;
      end
      if (exp_main.size() != 0 || exp_lsb.size() != 0) fail("drain_timeout");
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"},  32'(out_data),  32'd0);
      check({tag, "_full"},      32'(full),      32'd0);
      check({tag, "_bit_cnt"},   32'(bit_cnt),   32'd0);
      check({tag, "_overflow"},  32'(overflow),  32'd0);
      check({tag, "_errs"},      32'({err_char, err_short}), 32'd0);
   endtask

   // Monitor: compare every accepted output word against the scoreboard head.
   always @(negedge clk) begin
      if (!reset) begin
         if (err_char)  n_errc++;
         if (err_short) n_errs++;
         if (out_valid && out_ready) begin
            if (exp_main.size() == 0) fail("main_unexpected_word");
            else check("main_word", 32'(out_data), 32'(exp_main.pop_front()));
         end
         if (lsb_valid && lsb_ready) begin
            if (exp_lsb.size() == 0) fail("lsb_unexpected_word");
            else check("lsb_word", 32'(lsb_data), 32'(exp_lsb.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) step();
      check_all_zero("reset");
      reset = 1'b0;
      out_ready = 1'b1;
      step();

      // Single word with latency check.
      expect_word(8'hB1, 8'h8D, 1'b1);
      send_str("10110001");
      check("lat_push_cycle", 32'(out_valid), 32'd0);
      step();
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_data", 32'(out_data), 32'hB1);
      step();
      check("lat_one_cycle", 32'(out_valid), 32'd0);

      // Two words back-to-back; second word starts during PUSH.
      expect_word(8'hF0, 8'h0F, 1'b1);
      expect_word(8'h03, 8'hC0, 1'b1);
      send_str("1111000000000011");
      wait_drain();

      // Illegal characters and spaces are not counted.
      expect_word(8'hB6, 8'h6D, 1'b1);
      send_str("10x");
      check("errc_pulse", 32'(err_char), 32'd1);
      check("cnt_skip_illegal", 32'(bit_cnt), 32'd2);
      send_str("1 1A0110");
      wait_drain();
      check("errc_count", 32'(n_errc), 32'd2);

      // Terminators.
      send_byte(8'h0A);
      check("term_empty_no_err", 32'(err_short), 32'd0);
      send_str("101");
      check("cnt_partial", 32'(bit_cnt), 32'd3);
`ifdef ASCII_PACK_PAD_EN
      expect_word(8'hA0, 8'h05, 1'b1);
`endif
      send_byte(8'h0D);
      check("errs_pulse", 32'(err_short), 32'd1);
      step();
      check("cnt_after_term", 32'(bit_cnt), 32'd0);
      wait_drain();
      check("no_stray_word", 32'(out_valid), 32'd0);
      check("errs_count", 32'(n_errs), 32'd1);

      // Overflow: main stalls, fifth word dropped.
      out_ready = 1'b0;
      expect_word(8'h01, 8'h80, 1'b1); send_str("00000001");
      expect_word(8'h02, 8'h40, 1'b1); send_str("00000010");
      expect_word(8'h04, 8'h20, 1'b1); send_str("00000100");
      expect_word(8'h08, 8'h10, 1'b1); send_str("00001000");
      step();
      check("full_after_4", 32'(full), 32'd1);
      check("no_ovf_at_4", 32'(overflow), 32'd0);
      expect_word(8'h10, 8'h08, 1'b0); send_str("00010000");
      step();
      check("ovf_set", 32'(overflow), 32'd1);
      check("full_held", 32'(full), 32'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      out_ready = 1'b1;
      wait_drain();
      check("drained_empty", 32'(out_valid), 32'd0);

      // Full FIFO with a pop in the PUSH cycle: nothing lost.
      out_ready = 1'b0;
      expect_word(8'h11, 8'h88, 1'b1); send_str("00010001");
      expect_word(8'h22, 8'h44, 1'b1); send_str("00100010");
      expect_word(8'h33, 8'hCC, 1'b1); send_str("00110011");
      expect_word(8'h44, 8'h22, 1'b1); send_str("01000100");
      step();
      check("full_again", 32'(full), 32'd1);
      expect_word(8'h55, 8'hAA, 1'b1);
      send_str("01010101");
      out_ready = 1'b1;
      step();
      check("simul_no_ovf", 32'(overflow), 32'd0);
      check("simul_full", 32'(full), 32'd1);
      wait_drain();

      // Asynchronous reset mid-word.
      send_str("101");
      #2 reset = 1'b1;
      #1 check_all_zero("midreset");
      step();
      reset = 1'b0;
      expect_word(8'hB1, 8'h8D, 1'b1);
      send_str("10110001");
      wait_drain();

      check("main_q_empty", 32'(exp_main.size()), 32'd0);
      check("lsb_q_empty", 32'(exp_lsb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
